// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_driver
//  Purpose  : Binary-to-BCD conversion (sequential double-dabble) feeding a
//             multiplexed, time-scanned seven-segment display driver.
//  Options  : define SEG_LZB_EN to enable leading-zero blanking.
//  Revision : 1.0 - initial release
// ============================================================================
module seg_scan_driver #(
   parameter int NUM_DIGITS = 4,
   parameter int BIN_W      = 16,
   parameter int DWELL      = 10000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [BIN_W-1:0]      in_value,
   input  logic [NUM_DIGITS-1:0] dp_mask,
   output logic [NUM_DIGITS-1:0] an,
   output logic [7:0]            seg,
   output logic                  overflow
);

   // Decimal digits needed for the widest binary input: floor(BIN_W*log10(2))+1.
   // BIN_W*3/10 never lands on the wrong side of the floor for legal widths.
   localparam int c_BIN_DIGITS = (BIN_W * 3) / 10 + 1;
   // BCD shift register is at least as wide as the display so slices stay legal.
   localparam int c_BCD_DIGITS = (c_BIN_DIGITS > NUM_DIGITS) ? c_BIN_DIGITS : NUM_DIGITS;
   localparam int c_BCD_W      = 4 * c_BCD_DIGITS;
   localparam int c_CNT_W      = $clog2(BIN_W);
   localparam int c_IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int c_DWELL_W    = $clog2(DWELL);

   localparam logic [c_CNT_W-1:0]   c_CNT_LAST   = c_CNT_W'(BIN_W - 1);
   localparam logic [c_DWELL_W-1:0] c_DWELL_LAST = c_DWELL_W'(DWELL - 1);
   localparam logic [c_IDX_W-1:0]   c_IDX_TOP    = c_IDX_W'(NUM_DIGITS - 1);

   localparam logic [1:0] c_IDLE   = 2'd0;
   localparam logic [1:0] c_SHIFT  = 2'd1;
   localparam logic [1:0] c_COMMIT = 2'd2;

   // conversion state
   logic [1:0]              r_state;
   logic [BIN_W-1:0]        r_bin;
   logic [c_BCD_W-1:0]      r_bcd;
   logic [c_CNT_W-1:0]      r_cnt;
   logic [NUM_DIGITS-1:0]   r_dp_cap;

   // display state
   logic [4*NUM_DIGITS-1:0] r_disp;
   logic [NUM_DIGITS-1:0]   r_dp;
   logic                    r_ovf;
   logic [c_DWELL_W-1:0]    r_dwell;
   logic [c_IDX_W-1:0]      r_idx;
   logic [NUM_DIGITS-1:0]   r_an;
   logic [7:0]              r_seg;

   logic [c_BCD_W-1:0]      w_adj;
   logic                    w_unused_top;
   logic                    w_ovf;
   logic [NUM_DIGITS-1:0]   w_blank;
   logic [NUM_DIGITS-1:0]   w_onehot;
   logic [3:0]              w_digit;
   logic                    w_dp_on;
   logic                    w_blank_cur;
   logic [6:0]              w_abcdefg;

   // Double-dabble correction: every BCD nibble of 5 or more gets +3 before the shift.
   generate
      for (genvar g = 0; g < c_BCD_DIGITS; g++) begin : g_dabble
         assign w_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ? (r_bcd[4*g +: 4] + 4'd3)
                                                           : r_bcd[4*g +: 4];
      end
   endgenerate

   // The top bit shifts out of the register; the register is sized so it is always zero.
   assign w_unused_top = w_adj[c_BCD_W-1];

   // Any nonzero BCD digit beyond the display width means the value does not fit.
   generate
      if (c_BCD_DIGITS > NUM_DIGITS) begin : g_ovf
         assign w_ovf = |r_bcd[c_BCD_W-1:4*NUM_DIGITS];
      end else begin : g_no_ovf
         assign w_ovf = 1'b0;
      end
   endgenerate

   assign in_ready = (r_state == c_IDLE);

   // Conversion FSM: capture, BIN_W shift cycles, one commit cycle into the display registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= c_IDLE;
         r_bin    <= '0;
         r_bcd    <= '0;
         r_cnt    <= '0;
         r_dp_cap <= '0;
         r_disp   <= '0;
         r_dp     <= '0;
         r_ovf    <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (in_valid) begin
                  r_bin    <= in_value;
                  r_dp_cap <= dp_mask;
                  r_bcd    <= '0;
                  r_cnt    <= '0;
                  r_state  <= c_SHIFT;
               end
            end
            c_SHIFT: begin
               r_bcd <= {w_adj[c_BCD_W-2:0], r_bin[BIN_W-1]};
               r_bin <= {r_bin[BIN_W-2:0], 1'b0};
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == c_CNT_LAST) begin
                  r_state <= c_COMMIT;
               end
            end
            c_COMMIT: begin
               r_disp  <= r_bcd[4*NUM_DIGITS-1:0];
               r_dp    <= r_dp_cap;
               r_ovf   <= w_ovf;
               r_state <= c_IDLE;
            end
            default: r_state <= c_IDLE;
         endcase
      end
   end

   // Scan timing: dwell counter wraps every DWELL cycles and steps the digit index downward.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dwell <= '0;
         r_idx   <= c_IDX_TOP;
      end else if (r_dwell == c_DWELL_LAST) begin
         r_dwell <= '0;
         r_idx   <= (r_idx == '0) ? c_IDX_TOP : (r_idx - 1'b1);
      end else begin
         r_dwell <= r_dwell + 1'b1;
      end
   end

`ifdef SEG_LZB_EN
   // A digit is a leading zero when it and every digit above it are zero; units never blank.
   generate
      for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lzb
         if (g == 0) begin : g_units
            assign w_blank[g] = 1'b0;
         end else begin : g_upper
            assign w_blank[g] = ~r_ovf & ~(|r_disp[4*NUM_DIGITS-1:4*g]);
         end
      end
   endgenerate
`else
   assign w_blank = '0;
`endif

   function automatic logic [6:0] f_decode(input logic [3:0] d);
      case (d)
         4'd0:    f_decode = 7'b0000001;
         4'd1:    f_decode = 7'b1001111;
         4'd2:    f_decode = 7'b0010010;
         4'd3:    f_decode = 7'b0000110;
         4'd4:    f_decode = 7'b1001100;
         4'd5:    f_decode = 7'b0100100;
         4'd6:    f_decode = 7'b0100000;
         4'd7:    f_decode = 7'b0001111;
         4'd8:    f_decode = 7'b0000000;
         4'd9:    f_decode = 7'b0000100;
         default: f_decode = 7'b1111111;
      endcase
   endfunction

   // Select the current digit, its dp bit and blanking flag, and build the one-hot enable.
   always_comb begin
      w_digit     = '0;
      w_dp_on     = 1'b0;
      w_blank_cur = 1'b0;
      w_onehot    = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (r_idx == c_IDX_W'(i)) begin
            w_digit     = r_disp[4*i +: 4];
            w_dp_on     = r_dp[i];
            w_blank_cur = w_blank[i];
            w_onehot[i] = 1'b1;
         end
      end
   end

   // Segment pattern: dash on overflow, dark when blanked, otherwise the decoded digit.
   always_comb begin
      if (r_ovf) begin
         w_abcdefg = 7'b1111110;
      end else if (w_blank_cur) begin
         w_abcdefg = 7'b1111111;
      end else begin
         w_abcdefg = f_decode(w_digit);
      end
   end

   // Output registers: display lines are glitch-free and dark during reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_an  <= '0;
         r_seg <= 8'hFF;
      end else begin
         r_an  <= w_onehot;
         r_seg <= {w_abcdefg, ~w_dp_on};
      end
   end

   assign an       = r_an;
   assign seg      = r_seg;
   assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_scan_driver
//  Purpose  : Self-checking bench for seg_scan_driver (4 digits, 16-bit input,
//             dwell of 4 cycles); honours SEG_LZB_EN when defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_driver;

   localparam int N  = 4;
   localparam int BW = 16;
   localparam int DW = 4;

   logic          clk      = 1'b0;
   logic          rst_n    = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [BW-1:0] in_value = '0;
   logic [N-1:0]  dp_mask  = '0;
   logic [N-1:0]  an;
   logic [7:0]    seg;
   logic          overflow;

   int n_checks = 0;
   int n_pass   = 0;

   seg_scan_driver #(.NUM_DIGITS(N), .BIN_W(BW), .DWELL(DW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_value (in_value),
      .dp_mask  (dp_mask),
      .an       (an),
      .seg      (seg),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct packed {
      logic [15:0]     value;
      logic [3:0]      dp;
      logic            ovf;
      logic [3:0][3:0] dig;   // expected digit codes, index 0 = units, 10 = dash
   } vec_t;

   vec_t tbl [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // a..g patterns; 10 = dash, 11 = blank
   function automatic logic [6:0] segs(input int code);
      case (code)
         0:       return 7'b0000001;
         1:       return 7'b1001111;
         2:       return 7'b0010010;
         3:       return 7'b0000110;
         4:       return 7'b1001100;
         5:       return 7'b0100100;
         6:       return 7'b0100000;
         7:       return 7'b0001111;
         8:       return 7'b0000000;
         9:       return 7'b0000100;
         10:      return 7'b1111110;
         default: return 7'b1111111;
      endcase
   endfunction

   // Reference: expected seg byte for digit i of value v with decimal-point mask dp.
   function automatic logic [7:0] model_seg(input int v, input logic [3:0] dp, input int i);
      int p = 1;
      int code;
      for (int k = 0; k < i; k++) p = p * 10;
      if (v >= 10000) code = 10;
      else begin
         code = (v / p) % 10;
`ifdef SEG_LZB_EN
         if (i > 0 && v < p) code = 11;
`endif
      end
      return {segs(code), ~dp[i]};
   endfunction

   function automatic logic [7:0] tbl_seg(input vec_t t, input int i);
      int code = int'(t.dig[i]);
`ifdef SEG_LZB_EN
      bit upper_zero = 1'b1;
      for (int k = i; k < N; k++) if (t.dig[k] != 4'd0) upper_zero = 1'b0;
      if (i > 0 && upper_zero && !t.ovf) code = 11;
`endif
      return {segs(code), ~t.dp[i]};
   endfunction

   // Offer one value and count the cycles in_ready stays low afterwards.
   task automatic send(input int v, input logic [3:0] dp, output int busy);
      int w = 0;
      @(negedge clk);
      while (!in_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      in_valid = 1'b1;
      in_value = v[15:0];
      dp_mask  = dp;
      @(negedge clk);
      in_valid = 1'b0;
      busy = 0;
      while (!in_ready && busy < 100) begin
         busy++;
         @(negedge clk);
      end
   endtask

   // Watch one full scan and compare the seg byte shown with each digit enable.
   task automatic check_scan(input logic [3:0][7:0] exp, input string name);
      bit seen [N];
      int got = 0;
      for (int i = 0; i < N; i++) seen[i] = 1'b0;
      for (int c = 0; c < 3 * N * DW && got < N; c++) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (an == (4'b0001 << i) && !seen[i]) begin
               seen[i] = 1'b1;
               got++;
               check($sformatf("%s seg digit%0d", name, i), seg, exp[i]);
            end
         end
      end
      if (got < N) check({name, " scan coverage"}, got, N);
   endtask

   initial begin
      int busy;
      int v;
      logic [3:0] dp;
      logic [3:0][7:0] e;

      tbl[0] = '{value:16'd1234,  dp:4'b0100, ovf:1'b0, dig:{4'd1, 4'd2, 4'd3, 4'd4}};
      tbl[1] = '{value:16'd10000, dp:4'b0000, ovf:1'b1, dig:{4'd10, 4'd10, 4'd10, 4'd10}};
      tbl[2] = '{value:16'd9999,  dp:4'b0000, ovf:1'b0, dig:{4'd9, 4'd9, 4'd9, 4'd9}};
      tbl[3] = '{value:16'd7,     dp:4'b0000, ovf:1'b0, dig:{4'd0, 4'd0, 4'd0, 4'd7}};
      tbl[4] = '{value:16'd0,     dp:4'b1111, ovf:1'b0, dig:{4'd0, 4'd0, 4'd0, 4'd0}};
      tbl[5] = '{value:16'd65535, dp:4'b1001, ovf:1'b1, dig:{4'd10, 4'd10, 4'd10, 4'd10}};
      tbl[6] = '{value:16'd1000,  dp:4'b1000, ovf:1'b0, dig:{4'd1, 4'd0, 4'd0, 4'd0}};

      // reset state
      repeat (2) @(negedge clk);
      check("reset an", an, 4'b0000);
      check("reset seg", seg, 8'hFF);
      check("reset overflow", overflow, 1'b0);
      check("reset in_ready", in_ready, 1'b1);

      // idle scan after reset: each digit enabled for DW cycles, MSD first
      rst_n = 1'b1;
      for (int t = 1; t <= 4 * DW; t++) begin
         @(negedge clk);
         check($sformatf("idle an t%0d", t), an, 4'b0001 << (3 - (t - 1) / DW));
         check($sformatf("idle seg t%0d", t), seg, model_seg(0, 4'b0000, 3 - (t - 1) / DW));
      end
      check("idle in_ready", in_ready, 1'b1);

      // table-driven vectors
      for (int j = 0; j < 7; j++) begin
         send(int'(tbl[j].value), tbl[j].dp, busy);
         check($sformatf("tbl%0d busy cycles", j), busy, BW + 1);
         check($sformatf("tbl%0d overflow", j), overflow, tbl[j].ovf);
         for (int i = 0; i < N; i++) e[i] = tbl_seg(tbl[j], i);
         check_scan(e, $sformatf("tbl%0d", j));
      end

      // value offered while busy is dropped, not queued
      @(negedge clk);
      while (!in_ready) @(negedge clk);
      in_valid = 1'b1;
      in_value = 16'd42;
      dp_mask  = 4'b0000;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      in_valid = 1'b1;
      in_value = 16'd5555;
      repeat (5) @(negedge clk);
      in_valid = 1'b0;
      busy = 0;
      while (!in_ready && busy < 100) begin
         busy++;
         @(negedge clk);
      end
      check("ignore busy bound", busy < 100, 1'b1);
      for (int i = 0; i < N; i++) e[i] = model_seg(42, 4'b0000, i);
      check_scan(e, "ignore5555");
      check("ignore no restart", in_ready, 1'b1);

      // reset in the middle of a conversion
      send(1234, 4'b0000, busy);
      for (int i = 0; i < N; i++) e[i] = model_seg(1234, 4'b0000, i);
      check_scan(e, "prereset");
      @(negedge clk);
      in_valid = 1'b1;
      in_value = 16'd321;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midreset an", an, 4'b0000);
      check("midreset seg", seg, 8'hFF);
      check("midreset overflow", overflow, 1'b0);
      check("midreset in_ready", in_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("postreset an", an, 4'b1000);
      check("postreset seg", seg, model_seg(0, 4'b0000, 3));
      for (int i = 0; i < N; i++) e[i] = model_seg(0, 4'b0000, i);
      check_scan(e, "postreset");

      // randomized values against the reference model
      for (int r = 0; r < 24; r++) begin
         case ($urandom_range(0, 3))
            0:       v = int'($urandom_range(0, 99));
            1:       v = int'($urandom_range(9990, 10010));
            default: v = int'($urandom_range(0, 65535));
         endcase
         dp = 4'($urandom_range(0, 15));
         send(v, dp, busy);
         check($sformatf("rnd%0d busy v=%0d", r, v), busy, BW + 1);
         check($sformatf("rnd%0d overflow v=%0d", r, v), overflow, v >= 10000);
         for (int i = 0; i < N; i++) e[i] = model_seg(v, dp, i);
         check_scan(e, $sformatf("rnd%0d v=%0d", r, v));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 Parameter BIN_W, default 16, binary input width (legal 4..32).
REQ-003 Parameter DWELL, default 10000, clk cycles each digit stays enabled (legal >= 2).
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  new value offered.
REQ-007 in_ready  output  1  block can accept a value this cycle.
REQ-008 in_value  input  BIN_W  unsigned binary value to display.
REQ-009 dp_mask  input  NUM_DIGITS  decimal-point enables, bit i = digit i (0 = units), captured with in_value.
REQ-010 an  output  NUM_DIGITS  digit enables, one-hot active-high, an[NUM_DIGITS-1] = most significant digit.
REQ-011 seg  output  8  segments active-low, seg[7:0] = a,b,c,d,e,f,g,dp.
REQ-012 overflow  output  1  displayed value exceeded NUM_DIGITS decimal digits.

Function
REQ-013 Conversion FSM states IDLE, SHIFT, COMMIT; in_ready SHALL be 1 only in IDLE.
REQ-014 Handshake: value and dp_mask captured when in_valid && in_ready at a rising edge; IDLE -> SHIFT.
REQ-015 SHIFT SHALL run sequential double-dabble, one bit per cycle, exactly BIN_W cycles, then -> COMMIT.
REQ-016 COMMIT SHALL, in one cycle, load display digit register, dp register and overflow, then -> IDLE.
REQ-017 Latency: accept at edge k -> display register and overflow updated at edge k+BIN_W+1; in_ready high again after edge k+BIN_W+1.
REQ-018 in_valid while in_ready=0 SHALL be ignored (no queuing).
REQ-019 Overflow: if captured value >= 10^NUM_DIGITS, overflow=1 and every digit SHALL show "-" (seg = 8'b11111101, dp per mask); otherwise overflow=0.
REQ-020 Scan: dwell counter counts 0..DWELL-1; on wrap, digit index decrements NUM_DIGITS-1 -> ... -> 0 -> NUM_DIGITS-1.
REQ-021 an and seg SHALL be registered; an = one-hot of current index, seg = decoded digit of current index, dp = NOT dp register bit.
REQ-022 Decode (a..g, active-low): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
REQ-023 A display-register update mid-dwell SHALL appear on seg one cycle later without restarting dwell counter or index.
REQ-024 NUM_DIGITS=1: an SHALL be constant 1 after reset; index never changes.

Reset
REQ-025 rst_n low SHALL immediately force: an=0, seg=8'hFF, overflow=0, in_ready=1, FSM=IDLE, display and dp registers=0, dwell counter=0, index=NUM_DIGITS-1.
REQ-026 Reset during SHIFT/COMMIT SHALL abort conversion; display register not updated.
REQ-027 First edge after rst_n rises SHALL drive an[NUM_DIGITS-1]=1 showing digit value 0.

Configuration
REQ-028 Macro SEG_LZB_EN defined: leading-zero blanking -- digits above the most significant nonzero digit show a..g off (dp still per mask); units digit never blanked; not applied when overflow=1.
REQ-029 SEG_LZB_EN undefined: all digits always decoded, leading zeros shown.

Verification (NUM_DIGITS=4, BIN_W=16, DWELL=4 unless stated)
REQ-030 Reset then idle -> an cycles 1000,0100,0010,0001 every 4 cycles, seg=8'b00000011 each digit, in_ready=1.
REQ-031 Send 1234, dp_mask=0100 -> in_ready low 17 cycles; then digits show 1,2,3,4 with dp lit (seg[0]=0) only on an=0100.
REQ-032 Send 10000 -> overflow=1, all digits seg=8'b11111101; then send 9999 -> overflow=0, all digits 0000100x.
REQ-033 Assert in_valid with 5555 during SHIFT of 42 -> 42 displayed, 5555 ignored.
REQ-034 SEG_LZB_EN, send 7 -> an=1000,0100,0010 show seg=8'hFF, an=0001 shows 00011111; send 0 -> units shows 0.
REQ-035 Pulse rst_n low mid-SHIFT of 321 (after prior 1234) -> outputs per REQ-025 immediately; display resumes with 0000.
